iob_eth_phy_loopback: RTL and testbench
=======================================

Name: iob_eth_phy_loopback

Overview:
PHY-side MII endpoint for the Ethernet core: the far end of the core's MII transmit and receive pins.
- Consumes nibbles the MAC drives on MTxEn/MTxD, strips the preamble and SFD, and checks the CRC32 FCS.
- Stores the frame in an internal byte buffer.
- Optionally replays the frame back to the MAC on MRxDv/MRxD with a fresh preamble.
- Used in simulation and FPGA self-test as the MAC's link partner; single clock, MII nibbles sampled/driven on clk_i with cke_i.

Parameters:
- BUFFER_W, 11, log2 of frame buffer capacity in bytes (2048).
- IFG_CYCLES, 24, enabled clk_i cycles between end of capture and replay start (min 1).
- PREAMBLE_NIB, 15, number of 0x5 nibbles emitted before SFD nibble 0xD on replay.

Ports:
- clk_i  in  1  clock; MII nibble rate when cke_i=1.
- arst_n_i  in  1  asynchronous active-low reset.
- cke_i  in  1  clock enable; 0 freezes all state.
- mii_tx_en_i  in  1  MAC transmit enable (MTxEn).
- mii_txd_i  in  4  MAC transmit nibble (MTxD), low nibble of each byte first.
- mii_rx_dv_o  out  1  data valid toward MAC (MRxDv).
- mii_rxd_o  out  4  nibble toward MAC (MRxD).
- loop_en_i  in  1  1: replay each accepted frame; sampled at end of capture.
- frame_done_o  out  1  one-cycle pulse at end of each capture.
- crc_ok_o  out  1  FCS status of last captured frame; valid from frame_done_o.
- frame_len_o  out  BUFFER_W+1  bytes of last frame incl. FCS, excl. preamble/SFD.
- align_err_o  out  1  last frame ended on an odd nibble count.
- overflow_o  out  1  last frame exceeded 2^BUFFER_W bytes.
- drop_cnt_o  out  8  frames discarded because replay was busy; saturates at 255.

Behaviour:
- Reset: all outputs 0; both FSMs in IDLE; CRC register 0xFFFFFFFF.
- Capture FSM:
  - IDLE: on mii_tx_en_i=1 with nibble 0x5 go to PRE. Enable with any other nibble goes to SKIP.
  - PRE: 0x5 stays in PRE; 0xD goes to DATA; any other nibble goes to SKIP. Enable falling in PRE goes to IDLE with no pulse.
  - DATA: nibble pairs form bytes, low nibble first. Each byte is written to buffer[addr], addr increments, and the byte is fed to the CRC (reflected poly 0xEDB88320, init 0xFFFFFFFF).
  - DATA ends when mii_tx_en_i=0 is sampled. Go to DONE.
  - DONE, one cycle: frame_done_o=1; latch frame_len_o, crc_ok_o, align_err_o, overflow_o; go to IDLE.
  - SKIP: wait for mii_tx_en_i=0, then IDLE; no pulse.
- Status rules:
  - crc_ok_o = (CRC register == 0xDEBB20E3) && len>=4 && !align_err && !overflow.
  - A trailing odd nibble is discarded and sets align_err_o.
  - At byte count 2^BUFFER_W, further writes stop, overflow_o is set, and frame_len_o saturates at 2^BUFFER_W.
- Replay FSM:
  - States IDLE, GAP, PRE, SFD, DATA.
  - Start condition: in DONE, loop_en_i=1 and the frame is eligible → GAP; counter loads IFG_CYCLES-1 and counts down to 0.
  - PRE drives PREAMBLE_NIB nibbles of 0x5. SFD drives one 0xD nibble.
  - DATA drives frame_len_o bytes from the buffer, low nibble then high, with no gaps. The buffer read is prefetched so the first data nibble directly follows SFD.
  - mii_rx_dv_o=1 throughout PRE/SFD/DATA and drops the cycle after the last nibble. mii_rxd_o=0 when dv=0.
- Buffer: single-clock simple dual-port RAM, write from capture, read from replay.
  - While replay is not IDLE, a new capture still runs CRC and status but does not write the buffer. Its DONE increments drop_cnt_o and it is not replayed.
  - Capture and replay ending in the same cycle: that frame is accepted, since replay reaches IDLE first.
- cke_i=0 holds every register and output.
- arst_n_i low mid-frame: both FSMs abort to IDLE immediately, dv=0; the partial frame is lost.

Optional Feature:
- Macro: IOB_ETH_PHY_DROP_BAD_EN.
- Defined: a frame is eligible only if crc_ok_o=1; bad, misaligned or overflowed frames are never replayed.
- Undefined: any frame with frame_len_o>0 and !overflow is replayed verbatim, bad FCS included, so the MAC's RX CRC checking can be exercised.

Decomposition:
Shared package iob_eth_phy_pkg:
- nibble constants NIB_PREAMBLE=4'h5, NIB_SFD=4'hD;
- CRC_POLY_REFL=32'hEDB88320, CRC_INIT=32'hFFFFFFFF, CRC_RESIDUE=32'hDEBB20E3;
- capture and replay FSM state encodings.

Sub-module iob_eth_phy_crc32: byte-wide combinational CRC32 next-state with a registered accumulator, inputs clear/enable.

Test Plan:
- 64-byte frame with valid FCS, loop_en_i=1 → frame_done_o pulse, crc_ok_o=1, frame_len_o=64. After 24 cycles dv rises: 15×0x5, 0xD, then 128 nibbles identical to the input.
- Same frame with the last FCS byte flipped → crc_ok_o=0. Replay present without the macro; no dv activity with IOB_ETH_PHY_DROP_BAD_EN.
- Frame ending after 129 data nibbles → align_err_o=1, frame_len_o=64, crc_ok_o=0.
- 2100-byte frame → overflow_o=1, frame_len_o=2048, no replay.
- Second frame started during replay of the first → replay of the first is unchanged and drop_cnt_o goes 0→1.
- arst_n_i low for 2 cycles mid-DATA of replay → dv=0 at once; all outputs 0; a subsequent clean frame is captured and replayed correctly.

Source files
------------

// File: rtl/iob_eth_phy_pkg.sv
// Shared constants, FSM encodings and CRC32 helper for the MII PHY loopback endpoint.
// Optional macro IOB_ETH_PHY_DROP_BAD_EN is consumed by iob_eth_phy_loopback.
package iob_eth_phy_pkg;

    localparam logic [3:0]  NIB_PREAMBLE  = 4'h5;
    localparam logic [3:0]  NIB_SFD       = 4'hD;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        CAP_IDLE,
        CAP_PRE,
        CAP_DATA,
        CAP_DONE,
        CAP_SKIP
    } cap_state_e;

    typedef enum logic [2:0] {
        RPL_IDLE,
        RPL_GAP,
        RPL_PRE,
        RPL_SFD,
        RPL_DATA
    } rpl_state_e;

    function automatic logic [31:0] crc32_byte(
        input logic [31:0] crc,
        input logic [7:0]  data
    );
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/iob_eth_phy_crc32.sv
// Byte-wide CRC32 accumulator (reflected, no final inversion).
// Residue after a frame plus its FCS is CRC_RESIDUE.
module iob_eth_phy_crc32
    import iob_eth_phy_pkg::*;
(
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        cke_i,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] r_crc;
    logic [31:0] w_crc_next;

    assign w_crc_next = crc32_byte(r_crc, data_i);
    assign crc_o      = r_crc;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_crc <= CRC_INIT;
        end else if (cke_i) begin
            if (clr_i) begin
                r_crc <= CRC_INIT;
            end else if (en_i) begin
                r_crc <= w_crc_next;
            end
        end
    end

endmodule

// File: rtl/iob_eth_phy_loopback.sv
// MII link-partner: captures MAC frames, checks FCS, optionally replays them.
// IOB_ETH_PHY_DROP_BAD_EN: only frames with a good FCS are replayed.
module iob_eth_phy_loopback
    import iob_eth_phy_pkg::*;
#(
    parameter int BUFFER_W     = 11,
    parameter int IFG_CYCLES   = 24,
    parameter int PREAMBLE_NIB = 15
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                cke_i,
    input  logic                mii_tx_en_i,
    input  logic [3:0]          mii_txd_i,
    output logic                mii_rx_dv_o,
    output logic [3:0]          mii_rxd_o,
    input  logic                loop_en_i,
    output logic                frame_done_o,
    output logic                crc_ok_o,
    output logic [BUFFER_W:0]   frame_len_o,
    output logic                align_err_o,
    output logic                overflow_o,
    output logic [7:0]          drop_cnt_o
);

    localparam int DEPTH   = 1 << BUFFER_W;
    localparam int CNT_MAX = (IFG_CYCLES > PREAMBLE_NIB) ? IFG_CYCLES : PREAMBLE_NIB;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [BUFFER_W:0] LEN_MAX = {1'b1, {BUFFER_W{1'b0}}};
    localparam logic [BUFFER_W:0] LEN_ONE = (BUFFER_W + 1)'(1);

    cap_state_e r_cap;
    cap_state_e w_cap_nxt;
    rpl_state_e r_rpl;
    rpl_state_e w_rpl_nxt;

    logic [3:0]        r_lo;
    logic              r_odd;
    logic [BUFFER_W:0] r_cnt;
    logic              r_ovf_run;
    logic [BUFFER_W:0] r_len;
    logic              r_crc_ok;
    logic              r_align;
    logic              r_ovf;
    logic [7:0]        r_drop;

    logic [CNT_W-1:0]  r_rcnt;
    logic [BUFFER_W:0] r_rpl_len;
    logic [BUFFER_W:0] r_rd_ptr;
    logic              r_rphase;
    logic [7:0]        r_rd_data;
    logic [7:0]        r_mem [DEPTH];

    logic [7:0]  w_byte;
    logic        w_byte_stb;
    logic        w_room;
    logic        w_wr_en;
    logic        w_cap_end;
    logic        w_done;
    logic        w_rpl_last;
    logic        w_busy;
    logic        w_eligible;
    logic        w_start;
    logic [31:0] w_crc;

    assign w_byte     = {mii_txd_i, r_lo};
    assign w_byte_stb = (r_cap == CAP_DATA) && mii_tx_en_i && r_odd;
    assign w_room     = (r_cnt != LEN_MAX);
    assign w_wr_en    = w_byte_stb && w_room && (r_rpl == RPL_IDLE);
    assign w_cap_end  = (r_cap == CAP_DATA) && !mii_tx_en_i;
    assign w_done     = (r_cap == CAP_DONE);

    // r_rd_ptr already points past the byte whose high nibble is on the wire
    assign w_rpl_last = (r_rpl == RPL_DATA) && r_rphase && (r_rd_ptr == r_rpl_len);
    assign w_busy     = (r_rpl != RPL_IDLE) && !w_rpl_last;

`ifdef IOB_ETH_PHY_DROP_BAD_EN
    assign w_eligible = r_crc_ok;
`else
    assign w_eligible = (r_len != '0) && !r_ovf;
`endif

    assign w_start = w_done && loop_en_i && w_eligible && !w_busy;

    iob_eth_phy_crc32 u_crc (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .cke_i    (cke_i),
        .clr_i    (r_cap == CAP_IDLE),
        .en_i     (w_byte_stb),
        .data_i   (w_byte),
        .crc_o    (w_crc)
    );

    always_comb begin
        w_cap_nxt = r_cap;
        unique case (r_cap)
            CAP_IDLE: begin
                if (mii_tx_en_i) begin
                    w_cap_nxt = (mii_txd_i == NIB_PREAMBLE) ? CAP_PRE : CAP_SKIP;
                end
            end
            CAP_PRE: begin
                if (!mii_tx_en_i) begin
                    w_cap_nxt = CAP_IDLE;
                end else if (mii_txd_i == NIB_SFD) begin
                    w_cap_nxt = CAP_DATA;
                end else if (mii_txd_i != NIB_PREAMBLE) begin
                    w_cap_nxt = CAP_SKIP;
                end
            end
            CAP_DATA: begin
                if (!mii_tx_en_i) begin
                    w_cap_nxt = CAP_DONE;
                end
            end
            CAP_DONE: w_cap_nxt = CAP_IDLE;
            CAP_SKIP: begin
                if (!mii_tx_en_i) begin
                    w_cap_nxt = CAP_IDLE;
                end
            end
            default: w_cap_nxt = CAP_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_cap     <= CAP_IDLE;
            r_lo      <= 4'h0;
            r_odd     <= 1'b0;
            r_cnt     <= '0;
            r_ovf_run <= 1'b0;
            r_len     <= '0;
            r_crc_ok  <= 1'b0;
            r_align   <= 1'b0;
            r_ovf     <= 1'b0;
            r_drop    <= 8'h00;
        end else if (cke_i) begin
            r_cap <= w_cap_nxt;
            if (r_cap == CAP_PRE) begin
                r_odd     <= 1'b0;
                r_cnt     <= '0;
                r_ovf_run <= 1'b0;
            end else if ((r_cap == CAP_DATA) && mii_tx_en_i) begin
                if (!r_odd) begin
                    r_lo <= mii_txd_i;
                end
                r_odd <= !r_odd;
                if (r_odd) begin
                    if (w_room) begin
                        r_cnt <= r_cnt + LEN_ONE;
                    end else begin
                        r_ovf_run <= 1'b1;
                    end
                end
            end
            // status is latched on the edge into DONE so it is valid with the pulse
            if (w_cap_end) begin
                r_len    <= r_cnt;
                r_align  <= r_odd;
                r_ovf    <= r_ovf_run;
                r_crc_ok <= (w_crc == CRC_RESIDUE) && (r_cnt >= 4) &&
                            !r_odd && !r_ovf_run;
            end
            if (w_done && w_busy && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (w_wr_en) begin
                r_mem[r_cnt[BUFFER_W-1:0]] <= w_byte;
            end
            r_rd_data <= r_mem[r_rd_ptr[BUFFER_W-1:0]];
        end
    end

    always_comb begin
        w_rpl_nxt = r_rpl;
        unique case (r_rpl)
            RPL_IDLE: w_rpl_nxt = RPL_IDLE;
            RPL_GAP: begin
                if (r_rcnt == '0) begin
                    w_rpl_nxt = RPL_PRE;
                end
            end
            RPL_PRE: begin
                if (r_rcnt == '0) begin
                    w_rpl_nxt = RPL_SFD;
                end
            end
            RPL_SFD: w_rpl_nxt = RPL_DATA;
            RPL_DATA: begin
                if (w_rpl_last) begin
                    w_rpl_nxt = RPL_IDLE;
                end
            end
            default: w_rpl_nxt = RPL_IDLE;
        endcase
        if (w_start) begin
            w_rpl_nxt = RPL_GAP;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_rpl     <= RPL_IDLE;
            r_rcnt    <= '0;
            r_rpl_len <= '0;
            r_rd_ptr  <= '0;
            r_rphase  <= 1'b0;
        end else if (cke_i) begin
            r_rpl <= w_rpl_nxt;
            if (w_start) begin
                r_rcnt    <= CNT_W'(IFG_CYCLES - 1);
                r_rpl_len <= r_len;
                r_rd_ptr  <= '0;
                r_rphase  <= 1'b0;
            end else if (r_rpl == RPL_GAP) begin
                if (r_rcnt == '0) begin
                    r_rcnt <= CNT_W'(PREAMBLE_NIB - 1);
                end else begin
                    r_rcnt <= r_rcnt - CNT_W'(1);
                end
            end else if (r_rpl == RPL_PRE) begin
                if (r_rcnt != '0) begin
                    r_rcnt <= r_rcnt - CNT_W'(1);
                end
            end else if (r_rpl == RPL_DATA) begin
                r_rphase <= !r_rphase;
                // advance on the low nibble so the next byte is read in time
                if (!r_rphase) begin
                    r_rd_ptr <= r_rd_ptr + LEN_ONE;
                end
            end
        end
    end

    always_comb begin
        mii_rx_dv_o = 1'b0;
        mii_rxd_o   = 4'h0;
        unique case (r_rpl)
            RPL_PRE: begin
                mii_rx_dv_o = 1'b1;
                mii_rxd_o   = NIB_PREAMBLE;
            end
            RPL_SFD: begin
                mii_rx_dv_o = 1'b1;
                mii_rxd_o   = NIB_SFD;
            end
            RPL_DATA: begin
                mii_rx_dv_o = 1'b1;
                mii_rxd_o   = r_rphase ? r_rd_data[7:4] : r_rd_data[3:0];
            end
            default: begin
                mii_rx_dv_o = 1'b0;
                mii_rxd_o   = 4'h0;
            end
        endcase
    end

    assign frame_done_o = w_done;
    assign crc_ok_o     = r_crc_ok;
    assign frame_len_o  = r_len;
    assign align_err_o  = r_align;
    assign overflow_o   = r_ovf;
    assign drop_cnt_o   = r_drop;

endmodule

// File: tb/tb_iob_eth_phy_loopback.sv
// Scoreboard bench for iob_eth_phy_loopback: random frames, FCS/status model,
// replay nibble stream and inter-frame-gap timing checked by a monitor.
module tb_iob_eth_phy_loopback;

    localparam int BW  = 11;
    localparam int IFG = 24;
    localparam int PRE = 15;
    localparam int CAP = 1 << BW;

    logic          clk_i       = 1'b0;
    logic          arst_n_i    = 1'b0;
    logic          cke_i       = 1'b1;
    logic          mii_tx_en_i = 1'b0;
    logic [3:0]    mii_txd_i   = 4'h0;
    logic          loop_en_i   = 1'b0;
    logic          mii_rx_dv_o;
    logic [3:0]    mii_rxd_o;
    logic          frame_done_o;
    logic          crc_ok_o;
    logic [BW:0]   frame_len_o;
    logic          align_err_o;
    logic          overflow_o;
    logic [7:0]    drop_cnt_o;

    iob_eth_phy_loopback #(
        .BUFFER_W     (BW),
        .IFG_CYCLES   (IFG),
        .PREAMBLE_NIB (PRE)
    ) dut (
        .clk_i        (clk_i),
        .arst_n_i     (arst_n_i),
        .cke_i        (cke_i),
        .mii_tx_en_i  (mii_tx_en_i),
        .mii_txd_i    (mii_txd_i),
        .mii_rx_dv_o  (mii_rx_dv_o),
        .mii_rxd_o    (mii_rxd_o),
        .loop_en_i    (loop_en_i),
        .frame_done_o (frame_done_o),
        .crc_ok_o     (crc_ok_o),
        .frame_len_o  (frame_len_o),
        .align_err_o  (align_err_o),
        .overflow_o   (overflow_o),
        .drop_cnt_o   (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int len;
        bit crc_ok;
        bit align;
        bit ovf;
        bit loop;
        int nnib;
    } stat_t;

    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    bit         last_en = 1'b0;
    bit         cke_rand = 1'b0;
    bit         prev_dv = 1'b0;
    int         burst_n = 0;
    int         drops = 0;
    int         rpl_last = 0;
    stat_t      stat_q[$];
    logic [3:0] pend_q[$];
    logic [3:0] exp_q[$];
    int         burst_q[$];
    int         gap_q[$];
    logic [7:0] frm[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    endtask

    // standard Ethernet CRC32 (with final inversion) over frm[0..n-1]
    function automatic logic [31:0] crc_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, frm[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic mk_frame(input int npay, input bit with_fcs);
        logic [31:0] f;
        frm.delete();
        for (int i = 0; i < npay; i++) frm.push_back(8'($urandom));
        if (with_fcs) begin
            f = crc_of(npay);
            frm.push_back(f[7:0]);
            frm.push_back(f[15:8]);
            frm.push_back(f[23:16]);
            frm.push_back(f[31:24]);
        end
    endtask

    always @(negedge clk_i) begin
        cke_i = cke_rand ? ($urandom_range(0, 7) != 0) : 1'b1;
    end

    always @(posedge clk_i) begin
        last_en = cke_i;
        if (cke_i) cyc++;
    end

    task automatic tick();
        do @(posedge clk_i); while (!cke_i);
        #1;
    endtask

    task automatic drive(input bit en, input logic [3:0] nib);
        mii_tx_en_i = en;
        mii_txd_i   = nib;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 4'h0);
    endtask

    task automatic send(input bit extra, input logic [3:0] xn, input bit loop);
        stat_t s;
        int    n;
        int    npre;
        logic [31:0] fcs;
        n = frm.size();
        s.ovf   = (n > CAP);
        s.len   = s.ovf ? CAP : n;
        s.align = extra;
        fcs = (n >= 4) ? {frm[n-1], frm[n-2], frm[n-3], frm[n-4]} : 32'h0;
        s.crc_ok = (n >= 4) && !extra && !s.ovf && (crc_of(n - 4) == fcs);
        s.loop  = loop;
        s.nnib  = 2 * s.len;
        for (int i = 0; i < s.len; i++) begin
            pend_q.push_back(frm[i][3:0]);
            pend_q.push_back(frm[i][7:4]);
        end
        stat_q.push_back(s);
        loop_en_i = loop;
        npre = $urandom_range(1, 15);
        repeat (npre) drive(1'b1, 4'h5);
        drive(1'b1, 4'hD);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, frm[i][3:0]);
            drive(1'b1, frm[i][7:4]);
        end
        if (extra) drive(1'b1, xn);
        drive(1'b0, 4'h0);
    endtask

    task automatic on_done();
        stat_t s;
        bit    busy;
        bit    elig;
        if (stat_q.size() == 0) begin
            chk("spurious_done", 1, 0);
        end else begin
            s = stat_q.pop_front();
            chk("frame_len", frame_len_o, s.len);
            chk("crc_ok", crc_ok_o, s.crc_ok);
            chk("align_err", align_err_o, s.align);
            chk("overflow", overflow_o, s.ovf);
            chk("drop_cnt", drop_cnt_o, drops);
            busy = (cyc < rpl_last);
`ifdef IOB_ETH_PHY_DROP_BAD_EN
            elig = s.crc_ok;
`else
            elig = (s.len > 0) && !s.ovf;
`endif
            if (busy && drops < 255) drops++;
            if (!busy && s.loop && elig) begin
                gap_q.push_back(cyc);
                repeat (PRE) exp_q.push_back(4'h5);
                exp_q.push_back(4'hD);
                for (int i = 0; i < s.nnib; i++) exp_q.push_back(pend_q.pop_front());
                burst_q.push_back(PRE + 1 + s.nnib);
                rpl_last = cyc + IFG + PRE + 1 + s.nnib;
            end else begin
                for (int i = 0; i < s.nnib; i++) void'(pend_q.pop_front());
            end
        end
    endtask

    always @(negedge clk_i) begin
        if (!arst_n_i) begin
            prev_dv = 1'b0;
            burst_n = 0;
        end else if (last_en) begin
            if (frame_done_o) on_done();
            if (mii_rx_dv_o) begin
                if (!prev_dv) begin
                    burst_n = 0;
                    if (gap_q.size() == 0) chk("unexpected_dv", 1, 0);
                    else chk("ifg_cycles", cyc - gap_q.pop_front(), IFG + 1);
                end
                if (exp_q.size() == 0) chk("extra_nibble", 1, 0);
                else chk("rx_nibble", mii_rxd_o, exp_q.pop_front());
                burst_n++;
            end else if (prev_dv) begin
                if (burst_q.size() == 0) chk("burst_unexpected", 1, 0);
                else chk("burst_len", burst_n, burst_q.pop_front());
                chk("rxd_idle", mii_rxd_o, 0);
            end
            prev_dv = mii_rx_dv_o;
        end
    end

    task automatic chk_zero(input string pfx);
        chk({pfx, "_dv"}, mii_rx_dv_o, 0);
        chk({pfx, "_rxd"}, mii_rxd_o, 0);
        chk({pfx, "_done"}, frame_done_o, 0);
        chk({pfx, "_crc_ok"}, crc_ok_o, 0);
        chk({pfx, "_len"}, frame_len_o, 0);
        chk({pfx, "_align"}, align_err_o, 0);
        chk({pfx, "_ovf"}, overflow_o, 0);
        chk({pfx, "_drop"}, drop_cnt_o, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        int n;
        int k;
        repeat (3) @(posedge clk_i);
        #2;
        chk_zero("reset");
        arst_n_i = 1'b1;
        cke_rand = 1'b1;
        idle(4);

        mk_frame(60, 1'b1);
        send(1'b0, 4'h0, 1'b1);
        idle(250);

        mk_frame(60, 1'b1);
        frm[63] = frm[63] ^ 8'hFF;
        send(1'b0, 4'h0, 1'b1);
        idle(250);

        mk_frame(60, 1'b1);
        send(1'b1, 4'($urandom), 1'b1);
        idle(250);

        mk_frame(2096, 1'b1);
        send(1'b0, 4'h0, 1'b1);
        idle(60);

        repeat (10) drive(1'b1, 4'h3);
        idle(5);
        repeat (5) drive(1'b1, 4'h5);
        idle(5);
        repeat (4) drive(1'b1, 4'h5);
        drive(1'b1, 4'h7);
        drive(1'b1, 4'hD);
        idle(5);
        mk_frame(0, 1'b0);
        send(1'b0, 4'h0, 1'b1);
        idle(20);

        mk_frame(60, 1'b1);
        send(1'b0, 4'h0, 1'b1);
        idle(30);
        mk_frame(16, 1'b1);
        send(1'b0, 4'h0, 1'b1);
        idle(300);

        mk_frame(40, 1'b1);
        send(1'b0, 4'h0, 1'b0);
        idle(50);

        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 100);
            if (n < 5) mk_frame(n, 1'b0);
            else mk_frame(n - 4, 1'b1);
            if ($urandom_range(0, 2) == 0) frm[0] = frm[0] ^ 8'h01;
            send($urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 3) != 0);
            idle(2 * n + 90);
        end

        mk_frame(60, 1'b1);
        send(1'b0, 4'h0, 1'b1);
        k = 0;
        while (!mii_rx_dv_o && k < 400) begin
            tick();
            k++;
        end
        chk("dv_before_reset", mii_rx_dv_o, 1);
        repeat (30) tick();
        #2 arst_n_i = 1'b0;
        #1;
        chk_zero("midrst");
        stat_q.delete();
        pend_q.delete();
        exp_q.delete();
        burst_q.delete();
        gap_q.delete();
        drops = 0;
        rpl_last = 0;
        repeat (2) @(posedge clk_i);
        #2 arst_n_i = 1'b1;
        idle(4);
        mk_frame(60, 1'b1);
        send(1'b0, 4'h0, 1'b1);
        idle(250);

        chk("exp_nibbles_left", exp_q.size(), 0);
        chk("status_left", stat_q.size(), 0);
        chk("bursts_left", burst_q.size(), 0);
        chk("pending_left", pend_q.size(), 0);
        chk("final_drop_cnt", drop_cnt_o, drops);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
